neuron_stream_loader: RTL and testbench
=======================================

Name: neuron_stream_loader

Overview:
- Upstream stage of neuron_lif.
- Deserializes an 8-bit byte stream from the chip pins into the neuron's weights, inputs, shift and threshold.
- Each vector is committed atomically.
- Issues a one-cycle enable pulse to neuron_lif after every complete input vector. Weights and parameters persist across many input vectors.

Parameters:
- SYNAPSES, 32, synapse count; multiple of 8, >= 8.
- THRESHOLD_BITS, $clog2(SYNAPSES)+1, threshold width; must be <= 8; matches neuron_lif THRESHOLD_BITS.
- NBYTES, SYNAPSES/8, payload bytes per weight/input vector (localparam).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  byte present.
- in_ready  out  1  loader accepts the byte; transfer occurs when in_valid && in_ready at posedge.
- abort  in  1  synchronous; discards the partial frame.
- weights  out  SYNAPSES  committed weights, to neuron_lif.
- inputs  out  SYNAPSES  committed input spikes, to neuron_lif.
- shift  out  3  committed decay shift.
- threshold  out  THRESHOLD_BITS  committed threshold.
- neuron_enable  out  1  one-cycle pulse; neuron_lif updates its membrane.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, byte counter=0, shadow=0.
  - weights=0, inputs=0, shift=0, threshold=all ones.
  - neuron_enable=0, busy=0, in_ready=1.
- Header byte (accepted in IDLE), opcode = in_data[7:6]; in_data[5:0] ignored:
  - 00 LOAD_W: next NBYTES bytes, LSB byte first, go into the shadow.
  - 01 LOAD_P: next 2 bytes. Byte0[2:0] -> shift shadow (bits 7:3 ignored). Byte1[THRESHOLD_BITS-1:0] -> threshold shadow (upper bits ignored).
  - 10 EXEC: next NBYTES bytes, LSB first, go into the input shadow.
  - 11 NOP: stay in IDLE; nothing changes.
- States: IDLE, RX_W, RX_P, RX_X, FIRE.
  - IDLE -> RX_W / RX_P / RX_X on the respective header.
  - RX_*: counter increments per accepted byte.
  - Payload byte k is written to shadow bits [8k+7:8k].
- Commit, at the edge where the last payload byte is accepted:
  - RX_W -> IDLE; weights <= shadow, visible the next cycle.
  - RX_P -> IDLE; shift and threshold updated together.
  - RX_X -> FIRE; inputs <= shadow.
- FIRE, exactly one cycle:
  - neuron_enable=1, in_ready=0, then -> IDLE.
  - Latency: last EXEC byte accepted at edge N -> inputs valid and neuron_enable high during cycle N+1 -> enable low and state IDLE at N+2.
- Output stability:
  - Committed outputs never change mid-frame.
  - Partial shadows are never visible on the outputs.
- in_ready is 1 in every state except FIRE. A byte held valid through FIRE is accepted on the following cycle as a header.
- in_valid gaps: any number of idle cycles between bytes is legal; the counter holds.
- abort=1:
  - Next state is IDLE and the counter clears.
  - Shadows are discarded; committed outputs are unchanged.
  - Any byte presented in that cycle is dropped, although in_ready stays 1.
  - abort during FIRE: the pulse still completes this cycle and the state returns to IDLE.
  - If abort and the last payload byte coincide, abort wins: no commit, no enable.
- Reset mid-frame: everything returns to reset values immediately; no pulse is generated.
- Counter width: $clog2(NBYTES+1). It never wraps because the frame terminates at NBYTES.

Decomposition:
- Shared package neuron_stream_pkg:
  - opcode constants OP_LOAD_W=2'b00, OP_LOAD_P=2'b01, OP_EXEC=2'b10, OP_NOP=2'b11;
  - state enum typedef;
  - PARAM_BYTES=2.
- One natural sub-module: byte_deserializer.
  - Parameterized by NBYTES.
  - Byte-indexed shadow register with write strobe, index and clear.
  - Instantiated once and shared by LOAD_W and EXEC, since frames are mutually exclusive.
- Top FSM owns the commit registers and the handshake.

Test Plan:
1. Reset, SYNAPSES=32, hold reset_n=0 then release -> weights=0, inputs=0, shift=0, threshold=6'h3F, neuron_enable=0, busy=0, in_ready=1.
2. Weight load, bytes 00,EF,BE,AD,DE with one-cycle in_valid gaps -> weights stays 0 after the 3rd payload byte; weights=32'hDEADBEEF the cycle after the 4th; no enable pulse.
3. Param load, bytes 40,FB,EA -> shift=3'd3, threshold=6'h2A; both update in the same cycle.
4. Exec, bytes 80,FF,FF,00,00 with in_valid held high afterwards -> inputs=32'h0000FFFF; neuron_enable high exactly one cycle with in_ready=0 that cycle; the next byte is accepted as a header afterwards.
5. Abort after 2 weight payload bytes (00,11,22, abort) then NOP byte C0 -> weights unchanged, busy=0, no enable. A subsequent complete frame 00,01,02,03,04 -> weights=32'h04030201.
6. reset_n pulled low asynchronously after 3 EXEC payload bytes -> all outputs return to reset values immediately; no neuron_enable pulse ever appears.

Source files
------------

// File: rtl/neuron_stream_loader_pkg.sv
// Shared opcodes, frame lengths and FSM state encoding for the neuron stream loader.
package neuron_stream_pkg;

   localparam logic [1:0] OP_LOAD_W = 2'b00;
   localparam logic [1:0] OP_LOAD_P = 2'b01;
   localparam logic [1:0] OP_EXEC   = 2'b10;
   localparam logic [1:0] OP_NOP    = 2'b11;

   localparam int PARAM_BYTES = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX_W,
      ST_RX_P,
      ST_RX_X,
      ST_FIRE
   } state_t;

endpackage

// File: rtl/neuron_stream_loader_if.sv
// Byte-stream handshake from the chip pins into the loader, including the abort line.
interface neuron_stream_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       abort;

   modport master (output in_data, output in_valid, output abort, input in_ready);
   modport slave  (input in_data, input in_valid, input abort, output in_ready);
endinterface

// File: rtl/neuron_stream_loader_byte_deserializer.sv
// Byte-indexed shadow register; merged_o shows the shadow with this cycle's byte already applied.
module byte_deserializer #(
   parameter  int NBYTES = 4,
   localparam int CW     = $clog2(NBYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  wr_i,
   input  logic [CW-1:0]         idx_i,
   input  logic [7:0]            byte_i,
   output logic [8*NBYTES-1:0]   merged_o
);

   logic [8*NBYTES-1:0] shadow_q;
   logic [8*NBYTES-1:0] shadow_d;

   // Merged view lets the owner commit on the same edge the final byte lands.
   always_comb begin
      shadow_d = shadow_q;
      for (int k = 0; k < NBYTES; k++) begin
         if (wr_i && (idx_i == CW'(k))) shadow_d[8*k +: 8] = byte_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     shadow_q <= '0;
      else if (clr_i) shadow_q <= '0;
      else            shadow_q <= shadow_d;
   end

   assign merged_o = shadow_d;

endmodule

// File: rtl/neuron_stream_loader.sv
// Deserializes a header-framed byte stream into committed neuron_lif weights, inputs and parameters.
//  state   | meaning
//  IDLE    | waiting for a header byte
//  RX_W    | collecting weight payload into the shared shadow
//  RX_P    | collecting shift / threshold payload
//  RX_X    | collecting input-spike payload into the shared shadow
//  FIRE    | one-cycle neuron_enable pulse, stream stalled
module neuron_stream_loader
   import neuron_stream_pkg::*;
#(
   parameter  int SYNAPSES       = 32,
   parameter  int THRESHOLD_BITS = $clog2(SYNAPSES) + 1,
   localparam int NBYTES         = SYNAPSES / 8,
   localparam int CW             = $clog2(NBYTES + 1)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   neuron_stream_if.slave            s,
   output logic [SYNAPSES-1:0]       weights,
   output logic [SYNAPSES-1:0]       inputs,
   output logic [2:0]                shift,
   output logic [THRESHOLD_BITS-1:0] threshold,
   output logic                      neuron_enable,
   output logic                      busy
);

   state_t                    state_q;
   logic [CW-1:0]             cnt_q;
   logic [2:0]                shift_sh_q;
   logic [SYNAPSES-1:0]       weights_q;
   logic [SYNAPSES-1:0]       inputs_q;
   logic [2:0]                shift_q;
   logic [THRESHOLD_BITS-1:0] thr_q;
   logic                      enable_q;
   logic                      busy_q;
   logic                      ready_q;

   logic                      accept;
   logic                      last_vec;
   logic                      sh_wr;
   logic                      sh_clr;
   logic [SYNAPSES-1:0]       merged;

   // A byte offered alongside abort is dropped even though in_ready is high.
   assign accept   = s.in_valid && ready_q && !s.abort;
   assign last_vec = (cnt_q == CW'(NBYTES - 1));
   assign sh_wr    = accept && ((state_q == ST_RX_W) || (state_q == ST_RX_X));
   assign sh_clr   = s.abort || (state_q == ST_IDLE);

   byte_deserializer #(.NBYTES(NBYTES)) u_deser (
      .clk      (clk),
      .rst_n    (reset_n),
      .clr_i    (sh_clr),
      .wr_i     (sh_wr),
      .idx_i    (cnt_q),
      .byte_i   (s.in_data),
      .merged_o (merged)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_sh_q <= '0;
         weights_q  <= '0;
         inputs_q   <= '0;
         shift_q    <= '0;
         thr_q      <= '1;
         enable_q   <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         enable_q <= 1'b0;
         ready_q  <= 1'b1;
         if (s.abort) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_sh_q <= '0;
            busy_q     <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (accept) begin
                     cnt_q <= '0;
                     case (s.in_data[7:6])
                        OP_LOAD_W: begin state_q <= ST_RX_W; busy_q <= 1'b1; end
                        OP_LOAD_P: begin state_q <= ST_RX_P; busy_q <= 1'b1; end
                        OP_EXEC:   begin state_q <= ST_RX_X; busy_q <= 1'b1; end
                        default:   ;
                     endcase
                  end
               end
               ST_RX_W: begin
                  if (accept) begin
                     if (last_vec) begin
                        weights_q <= merged;
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
               ST_RX_P: begin
                  if (accept) begin
                     if (cnt_q == CW'(PARAM_BYTES - 1)) begin
                        shift_q <= shift_sh_q;
                        thr_q   <= s.in_data[THRESHOLD_BITS-1:0];
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                     end else begin
                        shift_sh_q <= s.in_data[2:0];
                        cnt_q      <= cnt_q + 1'b1;
                     end
                  end
               end
               ST_RX_X: begin
                  if (accept) begin
                     if (last_vec) begin
                        inputs_q <= merged;
                        state_q  <= ST_FIRE;
                        cnt_q    <= '0;
                        enable_q <= 1'b1;
                        ready_q  <= 1'b0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
               ST_FIRE: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign s.in_ready    = ready_q;
   assign weights       = weights_q;
   assign inputs        = inputs_q;
   assign shift         = shift_q;
   assign threshold     = thr_q;
   assign neuron_enable = enable_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_neuron_stream_loader.sv
// Scenario bench for neuron_stream_loader: expected enable pulses are queued when EXEC frames are sent.
module tb_neuron_stream_loader;

   localparam int SYN = 32;
   localparam int TB  = 6;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [SYN-1:0]  weights, inputs;
   logic [2:0]      shift;
   logic [TB-1:0]   threshold;
   logic            neuron_enable, busy;

   int tests_run = 0;
   int failures  = 0;
   logic [SYN-1:0] exp_q[$];
   logic prev_en = 1'b0;

   neuron_stream_if bus();

   neuron_stream_loader #(.SYNAPSES(SYN)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s             (bus),
      .weights       (weights),
      .inputs        (inputs),
      .shift         (shift),
      .threshold     (threshold),
      .neuron_enable (neuron_enable),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Pulse monitor: every enable must match a queued EXEC vector, last one cycle, and stall the stream.
   always @(negedge clk) begin
      if (prev_en) begin
         tests_run++;
         if (neuron_enable !== 1'b0) begin
            failures++;
            $display("FAIL enable_width: got %b want 0", neuron_enable);
         end
      end
      if (neuron_enable === 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_enable: got pulse with inputs=%h want none", inputs);
         end else begin
            logic [SYN-1:0] e;
            e = exp_q.pop_front();
            if (inputs !== e) begin
               failures++;
               $display("FAIL pulse_inputs: got %h want %h", inputs, e);
            end
         end
         tests_run++;
         if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fire_ready: got %b want 0", bus.in_ready);
         end
      end
      prev_en = neuron_enable;
   end

   task automatic send(input logic [7:0] b);
      int n;
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) begin
         tests_run++;
         failures++;
         $display("FAIL send_timeout: in_ready stuck low for byte %h", b);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({weights, inputs, shift, threshold, neuron_enable, busy, bus.in_ready} !==
          {32'h0, 32'h0, 3'd0, 6'h3F, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state: got w=%h x=%h sh=%0d th=%h en=%b busy=%b rdy=%b want w=0 x=0 sh=0 th=3f en=0 busy=0 rdy=1",
                  weights, inputs, shift, threshold, neuron_enable, busy, bus.in_ready);
      end
   endtask

   task automatic test_weight_load();
      send(8'h00); idle(1);
      send(8'hEF); idle(1);
      send(8'hBE); idle(1);
      send(8'hAD); idle(1);
      tests_run++;
      if (weights !== 32'h0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL w_partial: got w=%h busy=%b want w=0 busy=1", weights, busy);
      end
      send(8'hDE); idle(1);
      tests_run++;
      if (weights !== 32'hDEADBEEF || busy !== 1'b0) begin
         failures++;
         $display("FAIL w_commit: got w=%h busy=%b want deadbeef busy=0", weights, busy);
      end
   endtask

   task automatic test_param_load();
      send(8'h40);
      send(8'hFB); idle(1);
      tests_run++;
      if (shift !== 3'd0 || threshold !== 6'h3F) begin
         failures++;
         $display("FAIL p_partial: got sh=%0d th=%h want sh=0 th=3f", shift, threshold);
      end
      send(8'hEA); idle(1);
      tests_run++;
      if (shift !== 3'd3 || threshold !== 6'h2A) begin
         failures++;
         $display("FAIL p_commit: got sh=%0d th=%h want sh=3 th=2a", shift, threshold);
      end
   endtask

   task automatic test_exec_back_to_back();
      send(8'h80);
      send(8'hFF);
      send(8'hFF);
      send(8'h00);
      exp_q.push_back(32'h0000FFFF);
      send(8'h00);
      @(negedge clk);
      bus.in_data  = 8'h40;
      bus.in_valid = 1'b1;
      tests_run++;
      if (neuron_enable !== 1'b1 || inputs !== 32'h0000FFFF || busy !== 1'b1) begin
         failures++;
         $display("FAIL fire_cycle: got en=%b x=%h busy=%b want en=1 x=0000ffff busy=1", neuron_enable, inputs, busy);
      end
      @(negedge clk);
      tests_run++;
      if (neuron_enable !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL post_fire: got en=%b rdy=%b busy=%b want 0 1 0", neuron_enable, bus.in_ready, busy);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      tests_run++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL held_header: got busy=%b want 1", busy);
      end
      send(8'h05);
      send(8'h15); idle(1);
      tests_run++;
      if (shift !== 3'd5 || threshold !== 6'h15) begin
         failures++;
         $display("FAIL held_param: got sh=%0d th=%h want sh=5 th=15", shift, threshold);
      end
   endtask

   task automatic test_abort();
      send(8'h00);
      send(8'h11);
      send(8'h22);
      @(negedge clk);
      bus.in_data  = 8'h33;
      bus.in_valid = 1'b1;
      bus.abort    = 1'b1;
      @(negedge clk);
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || weights !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL abort_state: got busy=%b w=%h want busy=0 w=deadbeef", busy, weights);
      end
      send(8'hC0); idle(1);
      tests_run++;
      if (busy !== 1'b0 || weights !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL nop: got busy=%b w=%h want busy=0 w=deadbeef", busy, weights);
      end
      send(8'h00);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      send(8'h04); idle(1);
      tests_run++;
      if (weights !== 32'h04030201) begin
         failures++;
         $display("FAIL w_after_abort: got %h want 04030201", weights);
      end
      // abort coinciding with the final EXEC byte: no commit, no pulse
      send(8'h80);
      send(8'h12);
      send(8'h34);
      send(8'h56);
      @(negedge clk);
      bus.in_data  = 8'h78;
      bus.in_valid = 1'b1;
      bus.abort    = 1'b1;
      @(negedge clk);
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      idle(2);
      tests_run++;
      if (inputs !== 32'h0000FFFF || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_last: got x=%h busy=%b want x=0000ffff busy=0", inputs, busy);
      end
   endtask

   task automatic test_reset_midframe();
      send(8'h80);
      send(8'hAA);
      send(8'hBB);
      send(8'hCC);
      #3;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({weights, inputs, shift, threshold, neuron_enable, busy, bus.in_ready} !==
          {32'h0, 32'h0, 3'd0, 6'h3F, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_mid: got w=%h x=%h sh=%0d th=%h en=%b busy=%b rdy=%b want reset values",
                  weights, inputs, shift, threshold, neuron_enable, busy, bus.in_ready);
      end
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(4);
      tests_run++;
      if (busy !== 1'b0 || inputs !== 32'h0) begin
         failures++;
         $display("FAIL reset_release: got busy=%b x=%h want 0 0", busy, inputs);
      end
   endtask

   initial begin
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_weight_load();
      test_param_load();
      test_exec_back_to_back();
      test_abort();
      test_reset_midframe();
      tests_run++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_pulses: got %0d outstanding want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
